// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response channels of the ALU operation sequencer.
// The slave modport is the sequencer's view; master is the environment's.
interface alu_op_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic        req_wide;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [4:0]  req_amt;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_sel;
   logic        alu_cin;
   logic [31:0] alu_y;
   logic        alu_cout;
   logic        alu_neg;
   logic        alu_zero;
   logic        alu_ovf;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_y;
   logic        rsp_cout;
   logic        rsp_neg;
   logic        rsp_zero;
   logic        rsp_ovf;
   logic        rsp_err;

   modport slave (
      input  req_valid, req_op, req_wide, req_a, req_b, req_amt,
      input  alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
      input  rsp_ready,
      output req_ready,
      output alu_a, alu_b, alu_sel, alu_cin,
      output rsp_valid, rsp_y, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err
   );

   modport master (
      output req_valid, req_op, req_wide, req_a, req_b, req_amt,
      output alu_y, alu_cout, alu_neg, alu_zero, alu_ovf,
      output rsp_ready,
      input  req_ready,
      input  alu_a, alu_b, alu_sel, alu_cin,
      input  rsp_valid, rsp_y, rsp_cout, rsp_neg, rsp_zero, rsp_ovf, rsp_err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue/collect controller that splits 32/64-bit requests into single-cycle
// passes through an external combinational 32-bit ALU and returns the result.
module alu_op_sequencer #(
   parameter int unsigned MAX_AMT = 31
) (
   input  logic               clk,
   input  logic               rst,
   alu_op_sequencer_if.slave  bus
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_NOT  = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_ADD  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1010;
   localparam logic [3:0] OP_ASHL = 4'b1011;
   localparam logic [3:0] OP_LSR  = 4'b1100;
   localparam logic [3:0] OP_ASR  = 4'b1101;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXEC_LO = 3'd1,
      ST_EXEC_HI = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      MODE_ONE  = 2'd0,
      MODE_WIDE = 2'd1,
      MODE_NOP  = 2'd2,
      MODE_ERR  = 2'd3
   } mode_t;

   state_t      state_q;
   mode_t       mode_q;
   logic        ready_q;
   logic        sub_q;
   logic [63:0] a_q;
   logic [63:0] b_q;
   logic [4:0]  cnt_q;
   logic [31:0] w_q;
   logic [31:0] lo_y_q;

   logic [31:0] alu_a_q;
   logic [31:0] alu_b_q;
   logic [3:0]  alu_sel_q;
   logic        alu_cin_q;

   logic        rsp_valid_q;
   logic [63:0] rsp_y_q;
   logic        rsp_cout_q;
   logic        rsp_neg_q;
   logic        rsp_zero_q;
   logic        rsp_ovf_q;
   logic        rsp_err_q;

   logic        dec_addsub;
   logic        dec_shift;
   logic        dec_err;
   logic [4:0]  dec_amt;

   // Classify the incoming opcode and clamp the shift count.
   always_comb begin
      dec_addsub = 1'b0;
      dec_shift  = 1'b0;
      dec_err    = 1'b0;
      case (bus.req_op)
         OP_AND, OP_OR, OP_NOT, OP_NOR, OP_XOR, OP_NAND: dec_err = 1'b0;
         OP_ADD, OP_SUB:                                 dec_addsub = 1'b1;
         OP_SHL, OP_ASHL, OP_LSR, OP_ASR:                dec_shift = 1'b1;
         default:                                        dec_err = 1'b1;
      endcase
      if (bus.req_wide && !dec_addsub) begin
         dec_err = 1'b1;
      end else begin
         dec_err = dec_err;
      end
      if (32'(bus.req_amt) > MAX_AMT) begin
         dec_amt = 5'(MAX_AMT);
      end else begin
         dec_amt = bus.req_amt;
      end
   end

   // Sequencer FSM with registered ALU drive and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_ONE;
         ready_q     <= 1'b1;
         sub_q       <= 1'b0;
         a_q         <= 64'd0;
         b_q         <= 64'd0;
         cnt_q       <= 5'd0;
         w_q         <= 32'd0;
         lo_y_q      <= 32'd0;
         alu_a_q     <= 32'd0;
         alu_b_q     <= 32'd0;
         alu_sel_q   <= 4'd0;
         alu_cin_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_y_q     <= 64'd0;
         rsp_cout_q  <= 1'b0;
         rsp_neg_q   <= 1'b0;
         rsp_zero_q  <= 1'b0;
         rsp_ovf_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid && ready_q) begin
                  ready_q <= 1'b0;
                  a_q     <= bus.req_a;
                  b_q     <= bus.req_b;
                  sub_q   <= (bus.req_op == OP_SUB);
                  if (dec_err) begin
                     mode_q    <= MODE_ERR;
                     state_q   <= ST_EXEC_LO;
                     alu_a_q   <= 32'd0;
                     alu_b_q   <= 32'd0;
                     alu_sel_q <= 4'd0;
                     alu_cin_q <= 1'b0;
                  end else if (dec_shift && (dec_amt == 5'd0)) begin
                     mode_q    <= MODE_NOP;
                     state_q   <= ST_EXEC_LO;
                     alu_a_q   <= 32'd0;
                     alu_b_q   <= 32'd0;
                     alu_sel_q <= 4'd0;
                     alu_cin_q <= 1'b0;
                  end else if (dec_shift) begin
                     state_q   <= ST_SHIFT;
                     cnt_q     <= dec_amt;
                     w_q       <= bus.req_a[31:0];
                     alu_a_q   <= bus.req_a[31:0];
                     alu_b_q   <= 32'd0;
                     alu_sel_q <= bus.req_op;
                     alu_cin_q <= 1'b0;
                  end else if (bus.req_wide) begin
                     // Subtraction is done as A + ~B + 1 across both halves.
                     mode_q    <= MODE_WIDE;
                     state_q   <= ST_EXEC_LO;
                     alu_a_q   <= bus.req_a[31:0];
                     alu_b_q   <= (bus.req_op == OP_SUB) ? ~bus.req_b[31:0] : bus.req_b[31:0];
                     alu_sel_q <= OP_ADD;
                     alu_cin_q <= (bus.req_op == OP_SUB);
                  end else begin
                     mode_q    <= MODE_ONE;
                     state_q   <= ST_EXEC_LO;
                     alu_a_q   <= bus.req_a[31:0];
                     alu_b_q   <= bus.req_b[31:0];
                     alu_sel_q <= bus.req_op;
                     alu_cin_q <= 1'b0;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end

            ST_EXEC_LO: begin
               if (mode_q == MODE_WIDE) begin
                  state_q   <= ST_EXEC_HI;
                  lo_y_q    <= bus.alu_y;
                  alu_a_q   <= a_q[63:32];
                  alu_b_q   <= sub_q ? ~b_q[63:32] : b_q[63:32];
                  alu_sel_q <= OP_ADD;
                  alu_cin_q <= bus.alu_cout;
               end else begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  alu_a_q     <= 32'd0;
                  alu_b_q     <= 32'd0;
                  alu_sel_q   <= 4'd0;
                  alu_cin_q   <= 1'b0;
                  case (mode_q)
                     MODE_NOP: begin
                        rsp_y_q    <= {32'd0, a_q[31:0]};
                        rsp_cout_q <= 1'b0;
                        rsp_neg_q  <= a_q[31];
                        rsp_zero_q <= (a_q[31:0] == 32'd0);
                        rsp_ovf_q  <= 1'b0;
                        rsp_err_q  <= 1'b0;
                     end
                     MODE_ERR: begin
                        rsp_y_q    <= 64'd0;
                        rsp_cout_q <= 1'b0;
                        rsp_neg_q  <= 1'b0;
                        rsp_zero_q <= 1'b0;
                        rsp_ovf_q  <= 1'b0;
                        rsp_err_q  <= 1'b1;
                     end
                     default: begin
                        rsp_y_q    <= {32'd0, bus.alu_y};
                        rsp_cout_q <= bus.alu_cout;
                        rsp_neg_q  <= bus.alu_neg;
                        rsp_zero_q <= bus.alu_zero;
                        rsp_ovf_q  <= bus.alu_ovf;
                        rsp_err_q  <= 1'b0;
                     end
                  endcase
               end
            end

            ST_EXEC_HI: begin
               // Zero must cover both halves, so it is not taken from alu_zero.
               state_q     <= ST_RESP;
               rsp_valid_q <= 1'b1;
               rsp_y_q     <= {bus.alu_y, lo_y_q};
               rsp_cout_q  <= bus.alu_cout;
               rsp_neg_q   <= bus.alu_neg;
               rsp_zero_q  <= (lo_y_q == 32'd0) && (bus.alu_y == 32'd0);
               rsp_ovf_q   <= bus.alu_ovf;
               rsp_err_q   <= 1'b0;
               alu_a_q     <= 32'd0;
               alu_b_q     <= 32'd0;
               alu_sel_q   <= 4'd0;
               alu_cin_q   <= 1'b0;
            end

            ST_SHIFT: begin
               w_q <= bus.alu_y;
               if (cnt_q == 5'd1) begin
                  cnt_q       <= 5'd0;
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_y_q     <= {32'd0, bus.alu_y};
                  rsp_cout_q  <= bus.alu_cout;
                  rsp_neg_q   <= bus.alu_neg;
                  rsp_zero_q  <= bus.alu_zero;
                  rsp_ovf_q   <= bus.alu_ovf;
                  rsp_err_q   <= 1'b0;
                  alu_a_q     <= 32'd0;
                  alu_sel_q   <= 4'd0;
               end else begin
                  cnt_q   <= cnt_q - 5'd1;
                  alu_a_q <= bus.alu_y;
               end
            end

            ST_RESP: begin
               if (bus.rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end

            default: begin
               state_q     <= ST_IDLE;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b0;
               alu_sel_q   <= 4'd0;
            end
         endcase
      end
   end

   // Ready is masked combinationally so it drops in the reset cycle itself.
   assign bus.req_ready = ready_q & ~rst;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_sel   = alu_sel_q;
   assign bus.alu_cin   = alu_cin_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_y     = rsp_y_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.rsp_neg   = rsp_neg_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.rsp_ovf   = rsp_ovf_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU drives the DUT's ALU port and
// a whole-operation reference model predicts every response.
module tb_alu_op_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fails  = 0;
   int   last_wait = 0;

   alu_op_sequencer_if bif ();

   alu_op_sequencer #(.MAX_AMT(31)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] y;
      logic        cout, neg, zero, ovf, err;
      int          lat;
      logic [3:0]  sel;
      logic        cin_hi;
   } exp_t;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // 32-bit ALU as seen by the sequencer: returns {cout, neg, zero, ovf, y}.
   function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel, input logic cin);
      logic [32:0] s;
      logic [31:0] y;
      logic        c, v;
      s = 33'd0; y = 32'd0; c = 1'b0; v = 1'b0;
      case (sel)
         4'd0: y = a & b;
         4'd1: y = a | b;
         4'd2: y = ~a;
         4'd3: y = ~(a | b);
         4'd4: y = a ^ b;
         4'd5: y = ~(a & b);
         4'd6: begin
            s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            y = s[31:0]; c = s[32];
            v = (a[31] == b[31]) && (y[31] != a[31]);
         end
         4'd7: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            y = s[31:0]; c = s[32];
            v = (a[31] != b[31]) && (y[31] != a[31]);
         end
         4'd10: begin y = a << 1; c = a[31]; end
         4'd11: begin y = a << 1; c = a[31]; v = a[31] ^ a[30]; end
         4'd12: begin y = a >> 1; c = a[0]; end
         4'd13: begin y = {a[31], a[31:1]}; c = a[0]; end
         default: y = 32'd0;
      endcase
      return {c, y[31], (y == 32'd0), v, y};
   endfunction

   always_comb begin
      {bif.alu_cout, bif.alu_neg, bif.alu_zero, bif.alu_ovf, bif.alu_y} =
         alu_fn(bif.alu_a, bif.alu_b, bif.alu_sel, bif.alu_cin);
   end

   function automatic exp_t ref_model(input logic [3:0] op, input logic wide,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [4:0] amt);
      exp_t        e;
      logic [64:0] s;
      logic [32:0] lo;
      logic [31:0] y, prev, a32;
      logic [35:0] r;
      logic        is_lg, is_as, is_sh;
      e.y = 64'd0; e.cout = 1'b0; e.neg = 1'b0; e.zero = 1'b0; e.ovf = 1'b0;
      e.err = 1'b0; e.lat = 1; e.sel = 4'd0; e.cin_hi = 1'b0;
      a32   = a[31:0];
      is_lg = (op <= 4'd5);
      is_as = (op == 4'd6) || (op == 4'd7);
      is_sh = (op >= 4'd10) && (op <= 4'd13);
      if (!(is_lg || is_as || is_sh) || (wide && !is_as)) begin
         e.err = 1'b1;
      end else if (wide) begin
         if (op == 4'd7) begin
            s  = {1'b0, a} + {1'b0, ~b} + 65'd1;
            lo = {1'b0, a[31:0]} + {1'b0, ~b[31:0]} + 33'd1;
            e.ovf = (a[63] != b[63]) && (s[63] != a[63]);
         end else begin
            s  = {1'b0, a} + {1'b0, b};
            lo = {1'b0, a[31:0]} + {1'b0, b[31:0]};
            e.ovf = (a[63] == b[63]) && (s[63] != a[63]);
         end
         e.y = s[63:0]; e.cout = s[64]; e.neg = s[63]; e.zero = (s[63:0] == 64'd0);
         e.lat = 2; e.sel = 4'd6; e.cin_hi = lo[32];
      end else if (is_sh) begin
         if (amt == 5'd0) begin
            e.y = {32'd0, a32}; e.neg = a32[31]; e.zero = (a32 == 32'd0);
         end else begin
            if (op == 4'd10 || op == 4'd11) begin
               y = a32 << amt; prev = a32 << (amt - 5'd1);
               e.cout = prev[31];
               e.ovf  = (op == 4'd11) ? (prev[31] ^ prev[30]) : 1'b0;
            end else if (op == 4'd12) begin
               y = a32 >> amt; e.cout = a32[amt - 5'd1];
            end else begin
               y = $signed(a32) >>> amt; e.cout = a32[amt - 5'd1];
            end
            e.y = {32'd0, y}; e.neg = y[31]; e.zero = (y == 32'd0);
            e.lat = int'(amt); e.sel = op;
         end
      end else begin
         r = alu_fn(a[31:0], b[31:0], op, 1'b0);
         e.y = {32'd0, r[31:0]}; e.cout = r[35]; e.neg = r[34]; e.zero = r[33]; e.ovf = r[32];
         e.sel = op;
      end
      return e;
   endfunction

   // Called at a negedge; returns at a negedge with the DUT back in IDLE.
   task automatic run_op(input string tag, input logic [3:0] op, input logic wide,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] amt, input int hold);
      exp_t        e;
      int          lat, bad, unstable, waited;
      logic        done, cin2;
      logic [63:0] y0;
      e = ref_model(op, wide, a, b, amt);
      waited = 0;
      while (!bif.req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      last_wait = waited;
      check_eq({tag, " ready"}, 64'(bif.req_ready), 64'd1);
      bif.req_valid = 1'b1; bif.req_op = op; bif.req_wide = wide;
      bif.req_a = a; bif.req_b = b; bif.req_amt = amt;
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      bif.req_a = {$urandom, $urandom}; bif.req_b = {$urandom, $urandom};
      bif.req_op = 4'($urandom_range(0, 15)); bif.req_amt = 5'($urandom_range(0, 31));
      lat = 0; bad = 0; done = 1'b0; cin2 = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         if (bif.rsp_valid) begin
            done = 1'b1;
         end else begin
            lat++;
            if (bif.alu_sel !== e.sel) bad++;
            if (bif.req_ready) bad++;
            if (lat == 2) cin2 = bif.alu_cin;
         end
      end
      check_eq({tag, " latency"}, 64'(lat), 64'(e.lat));
      check_eq({tag, " pass drive"}, 64'(bad), 64'd0);
      if (!e.err && wide) check_eq({tag, " hi cin"}, 64'(cin2), 64'(e.cin_hi));
      check_eq({tag, " y"}, bif.rsp_y, e.y);
      check_eq({tag, " flags c/n/z/v/e"},
               64'({bif.rsp_cout, bif.rsp_neg, bif.rsp_zero, bif.rsp_ovf, bif.rsp_err}),
               64'({e.cout, e.neg, e.zero, e.ovf, e.err}));
      y0 = bif.rsp_y; unstable = 0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!bif.rsp_valid || (bif.rsp_y !== y0) || bif.req_ready || (bif.alu_sel !== 4'd0))
            unstable++;
      end
      check_eq({tag, " hold"}, 64'(unstable), 64'd0);
      bif.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bif.rsp_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, " release"}, 64'({bif.rsp_valid, bif.req_ready}), 64'({1'b0, 1'b1}));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt_v;
      rst = 1'b1;
      bif.req_valid = 1'b0; bif.req_op = 4'd0; bif.req_wide = 1'b0;
      bif.req_a = 64'd0; bif.req_b = 64'd0; bif.req_amt = 5'd0; bif.rsp_ready = 1'b0;
      @(negedge clk);
      check_eq("ready in reset", 64'(bif.req_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset outputs", {32'(bif.alu_a), 28'd0, bif.alu_sel},  64'd0);
      check_eq("reset rsp", 64'({bif.rsp_valid, bif.rsp_err, bif.rsp_y}), 64'd0);
      check_eq("ready after reset", 64'(bif.req_ready), 64'd1);

      run_op("add5+7",   4'd6,  1'b0, 64'd5, 64'd7, 5'd0, 0);
      run_op("wadd",     4'd6,  1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd0, 0);
      run_op("wsub0-1",  4'd7,  1'b1, 64'd0, 64'd1, 5'd0, 0);
      run_op("wsubeq",   4'd7,  1'b1, 64'h1234, 64'h1234, 5'd0, 0);
      run_op("lsr31",    4'd12, 1'b0, 64'h8000_0000, 64'd0, 5'd31, 0);
      run_op("asr31",    4'd13, 1'b0, 64'h8000_0000, 64'd0, 5'd31, 0);
      run_op("shl0",     4'd10, 1'b0, 64'h8000_0000, 64'd0, 5'd0, 0);
      run_op("bp add",   4'd6,  1'b0, 64'hFFFF_FFFF, 64'd1, 5'd0, 5);
      run_op("after bp", 4'd4,  1'b0, 64'hF0F0, 64'h0FF0, 5'd0, 0);
      check_eq("accept after bp", 64'(last_wait), 64'd0);
      run_op("bad op",   4'd9,  1'b0, 64'd3, 64'd4, 5'd0, 1);
      run_op("wide and", 4'd0,  1'b1, 64'd3, 64'd4, 5'd0, 0);

      // Reset in the middle of a long shift drops the operation silently.
      bif.req_valid = 1'b1; bif.req_op = 4'd12; bif.req_wide = 1'b0;
      bif.req_a = 64'h8000_0000; bif.req_amt = 5'd20;
      @(posedge clk);
      #1;
      bif.req_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("ready during rst", 64'(bif.req_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst mid-shift", 64'({bif.rsp_valid, bif.alu_sel, bif.req_ready}), 64'({1'b0, 4'd0, 1'b1}));
      check_eq("rst alu_a", 64'(bif.alu_a), 64'd0);
      cnt_v = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bif.rsp_valid || bif.alu_sel != 4'd0) cnt_v++;
      end
      check_eq("no rsp after rst", 64'(cnt_v), 64'd0);

      for (int n = 0; n < 200; n++) begin
         logic [3:0]  op_v;
         logic        wide_v;
         logic [63:0] a_v, b_v;
         op_v   = 4'($urandom_range(0, 15));
         wide_v = ($urandom_range(0, 3) == 0);
         if (wide_v && $urandom_range(0, 3) != 0) op_v = ($urandom_range(0, 1) == 0) ? 4'd6 : 4'd7;
         a_v = {$urandom, $urandom};
         b_v = ($urandom_range(0, 7) == 0) ? a_v : {$urandom, $urandom};
         run_op($sformatf("rnd%0d", n), op_v, wide_v, a_v, b_v,
                5'($urandom_range(0, 31)), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle issue/collect controller that drives the operand side of the 32-bit combinational ALU and collects its result and flags.
- Accepts 32- or 64-bit operation requests over a valid/ready handshake.
- Breaks each request into one or more single-cycle ALU passes:
  - 64-bit add/sub runs as low half then high half, with carry chained between them.
  - Shift-by-N runs as N single-bit ALU shifts.
- Returns the assembled result and flags over a second valid/ready handshake.

Parameters:
- MAX_AMT, 31, largest accepted shift amount; req_amt width is 5 bits.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  4  ALU select code (encoding below)
- req_wide  input  1  1 = 64-bit operation (add/sub only)
- req_a  input  64  operand A; bits [63:32] ignored when req_wide=0
- req_b  input  64  operand B; bits [63:32] ignored when req_wide=0
- req_amt  input  5  shift count for shift ops; ignored otherwise
- alu_a  output  32  ALU operand A
- alu_b  output  32  ALU operand B
- alu_sel  output  4  ALU select
- alu_cin  output  1  ALU carry-in
- alu_y  input  32  ALU result (combinational from alu_* outputs)
- alu_cout  input  1  ALU carry out
- alu_neg  input  1  ALU negative flag
- alu_zero  input  1  ALU zero flag
- alu_ovf  input  1  ALU overflow flag
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_y  output  64  result; [63:32]=0 for narrow ops
- rsp_cout  output  1  result carry flag
- rsp_neg  output  1  result negative flag
- rsp_zero  output  1  result zero flag
- rsp_ovf  output  1  result overflow flag
- rsp_err  output  1  unsupported op/mode

Behaviour:
- Opcodes and pass counts:
  - 0000 AND, 0001 OR, 0010 NOT, 0011 NOR, 0100 XOR, 0101 NAND: 1 pass.
  - 0110 ADD (A+B+cin), 0111 SUB: 1 pass narrow, 2 passes wide.
  - 1010 SHL, 1011 ASHL, 1100 LSR, 1101 ASR: shift by 1 per pass; req_amt passes.
  - Any other op, or req_wide=1 with a non-add/sub op: error.
- States: IDLE, EXEC_LO, EXEC_HI, SHIFT, RESP.
- Request handshake:
  - req_ready=1 only in IDLE and not in a reset cycle.
  - Acceptance happens on an edge where req_valid & req_ready; operands are registered on that edge.
- Passes: the ALU is combinational. In each EXEC/SHIFT cycle the sequencer drives alu_* from registers and samples alu_y/flags on the closing edge. One pass per cycle.
- Narrow non-shift: IDLE -> EXEC_LO -> RESP.
  - alu_a=A[31:0], alu_b=B[31:0], alu_sel=op, alu_cin=0.
  - rsp flags are the ALU flags from that pass.
- Wide add: EXEC_LO drives A[31:0], B[31:0], sel 0110, cin 0. EXEC_HI drives A[63:32], B[63:32], sel 0110, cin = registered low-pass alu_cout.
- Wide sub: sequencer-side two's complement, both passes sel 0110.
  - EXEC_LO: alu_b=~B[31:0], cin=1.
  - EXEC_HI: alu_b=~B[63:32], cin = low-pass cout.
- Wide flags:
  - cout, ovf, neg from the high pass.
  - zero = (low alu_y==0) & (high alu_y==0), computed in the sequencer, not from alu_zero.
- Shift:
  - Working register W=A[31:0]. Each SHIFT pass drives alu_a=W, alu_b=0, alu_sel=op, and loads W<=alu_y.
  - Stays in SHIFT until req_amt passes are done.
  - Flags come from the final pass.
  - req_amt=0: no ALU pass (one EXEC_LO cycle with alu_sel=0000). rsp_y=A, neg=A[31], zero=(A==0), cout=0, ovf=0.
- Error: one cycle in EXEC_LO with no pass (alu_sel=0000). rsp_err=1, rsp_y=0, all flags 0.
- Latency (accept edge to rsp_valid rise):
  - 1 cycle for 1-pass, amt=0 and error.
  - 2 cycles for wide.
  - N cycles for shift-by-N (N>=1).
- Response handshake:
  - RESP holds rsp_valid=1 and all rsp_* stable until rsp_valid & rsp_ready.
  - On that edge: go to IDLE, rsp_valid=0.
  - Earliest next acceptance is the edge after return to IDLE; no overlap of requests.
- Idle drive: outside EXEC/SHIFT, alu_a=0, alu_b=0, alu_sel=0000, alu_cin=0.
- Reset (any state, including mid-shift or in RESP):
  - Next edge: state IDLE, rsp_valid=0, all rsp_* = 0, alu_* = 0, W cleared.
  - req_ready=0 while rst is high; 1 in the first cycle after rst deasserts.
  - The in-flight operation is dropped without a response.

Test Plan:
- Narrow ADD A=5, B=7 -> rsp_y=12, cout/neg/zero/ovf=0, rsp_valid 1 cycle after acceptance.
- Wide ADD A=0x00000000_FFFFFFFF, B=1:
  - Second pass shows alu_cin=1.
  - rsp_y=0x00000001_00000000, zero=0, cout=0, ovf=0, latency 2.
- Wide SUB A=0, B=1 -> rsp_y=0xFFFFFFFF_FFFFFFFF, neg=1, cout=0, ovf=0, zero=0; wide SUB A=B=0x1234 -> zero=1, cout=1.
- Shifts on A=0x80000000:
  - LSR amt=31 -> rsp_y=0x00000001 after 31 cycles, alu_sel=1100 for exactly 31 cycles.
  - ASR amt=31 -> 0xFFFFFFFF.
  - SHL amt=0 -> y=0x80000000, neg=1, latency 1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 throughout.
  - Raise rsp_ready -> IDLE next edge, new request accepted the following edge.
- Errors and reset:
  - op=1001 -> rsp_err=1, y=0, alu_sel stays 0000.
  - Wide with op 0000 -> rsp_err=1.
  - rst pulsed during an LSR amt=20 at pass 10 -> next cycle IDLE, rsp_valid=0, alu_sel=0000, no response ever issued.
